console_writer: RTL and testbench

CONSOLE_WRITER -- requirements
Module: console_writer

---
 rtl/el_pkg.sv | 28 ++
 rtl/cell_fill.sv | 29 ++
 rtl/console_writer.sv | 151 +++++++++++++++
 tb/tb_console_writer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/el_pkg.sv
// Shared constants and types for the text console writer.
// Screen geometry, control codes and the writer FSM state.
package el_pkg;

  localparam int COLS = 40;
  localparam int ROWS = 32;
  localparam int CELLS = 1280;

  localparam logic [7:0] BLANK_CHAR = 8'h20;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] BS = 8'h08;
  localparam logic [7:0] FF = 8'h0C;

  typedef enum logic [1:0] {
    FILL_SCREEN,
    FILL_LINE,
    IDLE
  } state_t;

  function automatic logic is_printable(
    input logic [7:0] c
  );
    return (c >= 8'h20) && (c != 8'h7F);
  endfunction

endpackage

// File: rtl/cell_fill.sv
// Address-range walker for blank fills.
// Steps one cell per cycle from base while run is high.
module cell_fill (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        run,
  input  logic [10:0] base,
  input  logic [10:0] count,
  output logic [10:0] address,
  output logic        we,
  output logic        done
);

  logic [10:0] offset;

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      offset <= '0;
    end else if (run) begin
      offset <= offset + 11'd1;
    end
  end

  assign address = base + offset;
  assign we = run;
  assign done = run && (offset == count - 11'd1);

endmodule

// File: rtl/console_writer.sv
// Character-cell console writer: cursor control plus
// screen/line blank fills into a character RAM.
module console_writer #(
  parameter int COLS = el_pkg::COLS,
  parameter int ROWS = el_pkg::ROWS,
  parameter logic [7:0] BLANK_CHAR = el_pkg::BLANK_CHAR
) (
  input  logic        in_main_clock,
  input  logic        in_reset_n,
  input  logic        in_char_valid,
  input  logic [7:0]  in_char_data,
  output logic        out_char_ready,
  input  logic        in_clear_req,
  output logic        out_busy,
  output logic [10:0] out_wr_address,
  output logic [7:0]  out_wr_data,
  output logic        out_wr_en,
  output logic [5:0]  out_cursor_x,
  output logic [4:0]  out_cursor_y
);

  import el_pkg::*;

  state_t state, state_n;
  logic [5:0] x_n;
  logic [4:0] y_n;
  logic [4:0] y_wrap;
  logic wr_en_n;
  logic [10:0] wr_addr_n;
  logic [7:0] wr_data_n;
  logic [10:0] row_base;
  logic start, run, done, fill_we;
  logic [10:0] fill_addr, fill_base;
  logic [10:0] fill_count;

  assign row_base = 11'(out_cursor_y) * 11'(COLS);
  assign y_wrap = (out_cursor_y == 5'(ROWS - 1))
                ? '0 : out_cursor_y + 5'd1;

  assign out_char_ready = (state == IDLE) && !in_clear_req;
  assign out_busy = (state != IDLE);

  // A clear during a line fill stops the walker immediately.
  assign run = (state == FILL_SCREEN)
            || (state == FILL_LINE && !in_clear_req);
  assign fill_base = (state == FILL_LINE) ? row_base : '0;
  assign fill_count = (state == FILL_LINE)
                    ? 11'(COLS) : 11'(COLS * ROWS);

  cell_fill u_fill (
    .clk     (in_main_clock),
    .rst_n   (in_reset_n),
    .start   (start),
    .run     (run),
    .base    (fill_base),
    .count   (fill_count),
    .address (fill_addr),
    .we      (fill_we),
    .done    (done)
  );

  always_comb begin
    state_n = state;
    x_n = out_cursor_x;
    y_n = out_cursor_y;
    wr_en_n = 1'b0;
    wr_addr_n = out_wr_address;
    wr_data_n = out_wr_data;
    start = 1'b0;
    unique case (state)
      FILL_SCREEN, FILL_LINE: begin
        if (!run) begin
          x_n = '0;
          y_n = '0;
          start = 1'b1;
          state_n = FILL_SCREEN;
        end else begin
          wr_en_n = fill_we;
          wr_addr_n = fill_addr;
          wr_data_n = BLANK_CHAR;
          if (done) state_n = IDLE;
        end
      end
      IDLE: begin
        if (in_clear_req) begin
          x_n = '0;
          y_n = '0;
          start = 1'b1;
          state_n = FILL_SCREEN;
        end else if (in_char_valid) begin
          unique case (1'b1)
            is_printable(in_char_data): begin
              wr_en_n = 1'b1;
              wr_addr_n = row_base + 11'(out_cursor_x);
              wr_data_n = in_char_data;
              if (out_cursor_x == 6'(COLS - 1)) begin
                x_n = '0;
                y_n = y_wrap;
                start = 1'b1;
                state_n = FILL_LINE;
              end else begin
                x_n = out_cursor_x + 6'd1;
              end
            end
            in_char_data == CR: x_n = '0;
            in_char_data == LF: begin
              y_n = y_wrap;
              start = 1'b1;
              state_n = FILL_LINE;
            end
            in_char_data == BS: begin
              if (out_cursor_x != '0) begin
                x_n = out_cursor_x - 6'd1;
                wr_en_n = 1'b1;
                wr_addr_n = row_base + 11'(x_n);
                wr_data_n = BLANK_CHAR;
              end
            end
            in_char_data == FF: begin
              x_n = '0;
              y_n = '0;
              start = 1'b1;
              state_n = FILL_SCREEN;
            end
            default: ;
          endcase
        end
      end
      default: state_n = FILL_SCREEN;
    endcase
  end

  always_ff @(posedge in_main_clock) begin
    if (!in_reset_n) begin
      state <= FILL_SCREEN;
      out_cursor_x <= '0;
      out_cursor_y <= '0;
      out_wr_en <= 1'b0;
      out_wr_address <= '0;
      out_wr_data <= BLANK_CHAR;
    end else begin
      state <= state_n;
      out_cursor_x <= x_n;
      out_cursor_y <= y_n;
      out_wr_en <= wr_en_n;
      out_wr_address <= wr_addr_n;
      out_wr_data <= wr_data_n;
    end
  end

endmodule

// File: tb/tb_console_writer.sv
// Randomized bench for console_writer with a queue-based
// reference model checked every cycle.
module tb_console_writer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic clr = 1'b0;
  logic ready, busy, we;
  logic [10:0] wa;
  logic [7:0] wd;
  logic [5:0] cx;
  logic [4:0] cy;

  console_writer dut (
    .in_main_clock  (clk),
    .in_reset_n     (rst_n),
    .in_char_valid  (valid),
    .in_char_data   (data),
    .out_char_ready (ready),
    .in_clear_req   (clr),
    .out_busy       (busy),
    .out_wr_address (wa),
    .out_wr_data    (wd),
    .out_wr_en      (we),
    .out_cursor_x   (cx),
    .out_cursor_y   (cy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int d;
  } wr_t;

  wr_t wlog[$];
  int errors = 0;
  int checks = 0;

  // reference model: pending blank cells in a queue
  int q[$];
  bit screen;
  int mx = 0, my = 0;
  bit ewe, in_rst, m_acc;
  int eaddr, edata;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic fill_screen();
    q.delete();
    for (int i = 0; i < 1280; i++) q.push_back(i);
    screen = 1;
    mx = 0;
    my = 0;
  endtask

  task automatic new_line();
    my = (my + 1) % 32;
    q.delete();
    for (int i = 0; i < 40; i++) q.push_back(my * 40 + i);
    screen = 0;
  endtask

  task automatic model_step();
    int c;
    m_acc = 0;
    ewe = 0;
    in_rst = !rst_n;
    if (!rst_n) begin
      fill_screen();
      eaddr = 0;
      edata = 8'h20;
    end else if (q.size() > 0) begin
      if (clr && !screen) begin
        fill_screen();
      end else begin
        eaddr = q.pop_front();
        edata = 8'h20;
        ewe = 1;
      end
    end else if (clr) begin
      fill_screen();
    end else if (valid) begin
      m_acc = 1;
      c = int'(data);
      if (c == 8'h0C) begin
        fill_screen();
      end else if (c == 8'h0D) begin
        mx = 0;
      end else if (c == 8'h0A) begin
        new_line();
      end else if (c == 8'h08) begin
        if (mx > 0) begin
          mx--;
          ewe = 1;
          eaddr = my * 40 + mx;
          edata = 8'h20;
        end
      end else if (c >= 8'h20 && c != 8'h7F) begin
        ewe = 1;
        eaddr = my * 40 + mx;
        edata = c;
        mx++;
        if (mx == 40) begin
          mx = 0;
          new_line();
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    if (we) wlog.push_back('{int'(wa), int'(wd)});
    check("wr_en", we, ewe);
    if (ewe || in_rst) begin
      check("wr_addr", wa, eaddr);
      check("wr_data", wd, edata);
    end
    check("cursor_x", cx, mx);
    check("cursor_y", cy, my);
    check("busy", busy, q.size() != 0);
    check("ready", ready, (q.size() == 0) && !clr);
  end

  function automatic int bad_range(input int n,
                                   input int base);
    int bad = 0;
    if (wlog.size() != n) bad++;
    for (int i = 0; i < n && i < wlog.size(); i++)
      if (wlog[i].a != base + i || wlog[i].d != 8'h20)
        bad++;
    return bad;
  endfunction

  task automatic send(input logic [7:0] c);
    int n = 0;
    @(negedge clk);
    valid = 1'b1;
    data = c;
    forever begin
      @(posedge clk);
      #2;
      if (m_acc) break;
      n++;
      if (n > 3000) begin
        check("send_timeout", 1, 0);
        break;
      end
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        check("idle_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  function automatic logic [7:0] rand_byte();
    int r = $urandom_range(0, 15);
    logic [7:0] b;
    case (r)
      0: b = 8'h0D;
      1: b = 8'h0A;
      2, 3: b = 8'h08;
      4: b = ($urandom_range(0, 1) == 1) ? 8'h7F
            : 8'(($urandom_range(0, 2) * 2) + 1);
      5: b = ($urandom_range(0, 7) == 0) ? 8'h0C : 8'h41;
      default: begin
        b = 8'($urandom_range(32, 255));
        if (b == 8'h7F) b = 8'h7E;
      end
    endcase
    return b;
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_ready", ready, 0);
    check("rst_wa", wa, 0);
    rst_n = 1'b1;
    wlog.delete();
    wait_idle();
    check("boot_fill", bad_range(1280, 0), 0);
    check("boot_busy", busy, 0);
    check("boot_ready", ready, 1);

    wlog.delete();
    send(8'h41);
    send(8'h42);
    check("ab_count", wlog.size(), 2);
    check("a_write", (wlog[0].a << 8) | wlog[0].d,
          (0 << 8) | 8'h41);
    check("b_write", (wlog[1].a << 8) | wlog[1].d,
          (1 << 8) | 8'h42);
    check("ab_x", cx, 2);
    check("ab_y", cy, 0);

    send(8'h0C);
    wait_idle();
    wlog.delete();
    repeat (40) send(8'h78);
    wait_idle();
    check("row_last", (wlog[39].a << 8) | wlog[39].d,
          (39 << 8) | 8'h78);
    wlog = wlog[40:$];
    check("row_fill", bad_range(40, 40), 0);
    check("row_x", cx, 0);
    check("row_y", cy, 1);

    repeat (30) send(8'h0A);
    wait_idle();
    check("lf_y31", cy, 31);
    wlog.delete();
    send(8'h0A);
    wait_idle();
    check("wrap_y", cy, 0);
    check("wrap_fill", bad_range(40, 0), 0);
    wlog.delete();
    send(8'h08);
    repeat (3) @(negedge clk);
    check("bs_nowrite", wlog.size(), 0);
    check("bs_x", cx, 0);

    send(8'h0A);
    repeat (5) @(negedge clk);
    wlog.delete();
    clr = 1'b1;
    valid = 1'b1;
    data = 8'h5A;
    @(negedge clk);
    clr = 1'b0;
    valid = 1'b0;
    wait_idle();
    check("abort_fill", bad_range(1280, 0), 0);
    check("abort_x", cx, 0);
    check("abort_y", cy, 0);

    send(8'h0C);
    wlog.delete();
    repeat (500) @(negedge clk);
    check("mid_count", wlog.size(), 500);
    check("mid_last", wlog[wlog.size() - 1].a, 499);
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_we", we, 0);
    check("mrst_wa", wa, 0);
    check("mrst_wd", wd, 8'h20);
    check("mrst_busy", busy, 1);
    check("mrst_ready", ready, 0);
    rst_n = 1'b1;
    wlog.delete();
    @(negedge clk);
    check("restart_addr", wlog[0].a, 0);
    wait_idle();
    check("restart_fill", bad_range(1280, 0), 0);

    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 39) == 0) pulse_clear();
      else send(rand_byte());
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
